// File: rtl/memtile_sched_ctrl.sv
// Dual-channel loop-nest schedule/address sequencer for a single memory tile.
// Each channel fires when the shared cycle counter matches its running schedule sum.
module memtile_sched_chan #(
  parameter int NUM_DIMS = 6,
  parameter int W        = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  clk_en,
  input  logic [W-1:0]          t,
  input  logic [3:0]            dimensionality,
  input  logic [NUM_DIMS*W-1:0] ranges,
  input  logic [W-1:0]          sched_start,
  input  logic [NUM_DIMS*W-1:0] sched_strides,
  input  logic [W-1:0]          addr_start,
  input  logic [NUM_DIMS*W-1:0] addr_strides,
  output logic                  fire,
  output logic [W-1:0]          addr,
  output logic                  done
);
  localparam logic [W-1:0] ZERO_W = {W{1'b0}};
  localparam logic [W-1:0] ONE_W  = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] iter_r          [NUM_DIMS];
  logic [W-1:0] sched_off_r     [NUM_DIMS];
  logic [W-1:0] addr_off_r      [NUM_DIMS];
  logic [W-1:0] iter_nxt_s      [NUM_DIMS];
  logic [W-1:0] sched_off_nxt_s [NUM_DIMS];
  logic [W-1:0] addr_off_nxt_s  [NUM_DIMS];
  logic         done_r;
  logic [3:0]   dim_s;
  logic         enabled_s;
  logic         fire_s;
  logic         carry_s;
  logic         last_s;
  logic [W-1:0] sched_s;
  logic [W-1:0] addr_s;

  // Clamp depth and sum the per-dimension running offsets into S and A
  always_comb begin
    if (dimensionality > 4'(NUM_DIMS)) begin
      dim_s = 4'(NUM_DIMS);
    end else begin
      dim_s = dimensionality;
    end
    enabled_s = (dim_s != 4'd0);
    sched_s   = sched_start;
    addr_s    = addr_start;
    for (int d = 0; d < NUM_DIMS; d++) begin
      if (d < int'(dim_s)) begin
        sched_s = sched_s + sched_off_r[d];
        addr_s  = addr_s + addr_off_r[d];
      end else begin
        sched_s = sched_s;
        addr_s  = addr_s;
      end
    end
    // rst_n gating keeps strobes low while reset is held, even when t matches S
    fire_s = rst_n & ~flush & clk_en & enabled_s & ~done_r & (t == sched_s);
  end

  // Odometer advance: bump the innermost dimension, ripple wraps outward
  always_comb begin
    carry_s = 1'b1;
    for (int d = 0; d < NUM_DIMS; d++) begin
      iter_nxt_s[d]      = iter_r[d];
      sched_off_nxt_s[d] = sched_off_r[d];
      addr_off_nxt_s[d]  = addr_off_r[d];
      if (carry_s && (d < int'(dim_s))) begin
        if ((iter_r[d] + ONE_W) == ranges[d*W +: W]) begin
          iter_nxt_s[d]      = ZERO_W;
          sched_off_nxt_s[d] = ZERO_W;
          addr_off_nxt_s[d]  = ZERO_W;
        end else begin
          iter_nxt_s[d]      = iter_r[d] + ONE_W;
          sched_off_nxt_s[d] = sched_off_r[d] + sched_strides[d*W +: W];
          addr_off_nxt_s[d]  = addr_off_r[d] + addr_strides[d*W +: W];
          carry_s            = 1'b0;
        end
      end else begin
        carry_s = carry_s;
      end
    end
    last_s = carry_s & enabled_s;
  end

  // Iteration state: cleared by reset/flush, advanced only on fire
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < NUM_DIMS; d++) begin
        iter_r[d]      <= ZERO_W;
        sched_off_r[d] <= ZERO_W;
        addr_off_r[d]  <= ZERO_W;
      end
      done_r <= 1'b0;
    end else if (flush) begin
      for (int d = 0; d < NUM_DIMS; d++) begin
        iter_r[d]      <= ZERO_W;
        sched_off_r[d] <= ZERO_W;
        addr_off_r[d]  <= ZERO_W;
      end
      done_r <= 1'b0;
    end else if (fire_s) begin
      for (int d = 0; d < NUM_DIMS; d++) begin
        iter_r[d]      <= iter_nxt_s[d];
        sched_off_r[d] <= sched_off_nxt_s[d];
        addr_off_r[d]  <= addr_off_nxt_s[d];
      end
      done_r <= last_s;
    end else begin
      for (int d = 0; d < NUM_DIMS; d++) begin
        iter_r[d]      <= iter_r[d];
        sched_off_r[d] <= sched_off_r[d];
        addr_off_r[d]  <= addr_off_r[d];
      end
      done_r <= done_r;
    end
  end

  assign fire = fire_s;
  assign addr = fire_s ? addr_s : ZERO_W;
  // A disabled channel reports done from cycle 0 without waiting for a fire
  assign done = done_r | (~enabled_s & rst_n & ~flush);
endmodule

module memtile_sched_ctrl #(
  parameter int NUM_DIMS = 6,
  parameter int W        = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  clk_en,
  input  logic [3:0]            wr_dimensionality,
  input  logic [NUM_DIMS*W-1:0] wr_ranges,
  input  logic [W-1:0]          wr_sched_start,
  input  logic [NUM_DIMS*W-1:0] wr_sched_strides,
  input  logic [W-1:0]          wr_addr_start,
  input  logic [NUM_DIMS*W-1:0] wr_addr_strides,
  input  logic [3:0]            rd_dimensionality,
  input  logic [NUM_DIMS*W-1:0] rd_ranges,
  input  logic [W-1:0]          rd_sched_start,
  input  logic [NUM_DIMS*W-1:0] rd_sched_strides,
  input  logic [W-1:0]          rd_addr_start,
  input  logic [NUM_DIMS*W-1:0] rd_addr_strides,
  output logic                  wen,
  output logic [W-1:0]          waddr,
  output logic                  ren,
  output logic [W-1:0]          raddr,
  output logic                  wr_done,
  output logic                  rd_done,
  output logic                  conflict
);
  localparam logic [W-1:0] ZERO_W = {W{1'b0}};
  localparam logic [W-1:0] ONE_W  = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] t_r;
  logic         conflict_r;
  logic         wr_fire_s;
  logic         rd_fire_s;

  // Shared cycle counter, wraps modulo 2^W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_r <= ZERO_W;
    end else if (flush) begin
      t_r <= ZERO_W;
    end else if (clk_en) begin
      t_r <= t_r + ONE_W;
    end else begin
      t_r <= t_r;
    end
  end

  // Sticky single-port conflict flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_r <= 1'b0;
    end else if (flush) begin
      conflict_r <= 1'b0;
    end else if (wr_fire_s && rd_fire_s) begin
      conflict_r <= 1'b1;
    end else begin
      conflict_r <= conflict_r;
    end
  end

  memtile_sched_chan #(.NUM_DIMS(NUM_DIMS), .W(W)) u_wr (
    .clk(clk), .rst_n(rst_n), .flush(flush), .clk_en(clk_en), .t(t_r),
    .dimensionality(wr_dimensionality), .ranges(wr_ranges),
    .sched_start(wr_sched_start), .sched_strides(wr_sched_strides),
    .addr_start(wr_addr_start), .addr_strides(wr_addr_strides),
    .fire(wr_fire_s), .addr(waddr), .done(wr_done)
  );

  memtile_sched_chan #(.NUM_DIMS(NUM_DIMS), .W(W)) u_rd (
    .clk(clk), .rst_n(rst_n), .flush(flush), .clk_en(clk_en), .t(t_r),
    .dimensionality(rd_dimensionality), .ranges(rd_ranges),
    .sched_start(rd_sched_start), .sched_strides(rd_sched_strides),
    .addr_start(rd_addr_start), .addr_strides(rd_addr_strides),
    .fire(rd_fire_s), .addr(raddr), .done(rd_done)
  );

  assign wen      = wr_fire_s;
  assign ren      = rd_fire_s;
  assign conflict = conflict_r;
endmodule
